// File: rtl/flip_sched.sv
// Round-robin scheduler sharing one fixed-latency inversion datapath among N requesters.
// A grant samples the winner's operand; the result is held in DONE until the consumer accepts it.
module flip_sched #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int LAT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
  input  logic [N*W-1:0]       din_i,
  input  logic                 rdy_i,
  output logic [N-1:0]         gnt_o,
  output logic                 vld_o,
  output logic [W-1:0]         dout_o,
  output logic [$clog2(N)-1:0] src_o,
  output logic                 busy_o
);

  localparam int SW = $clog2(N);
  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  ptr_q, ptr_d, id_q, id_d, src_q, src_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           vld_q, vld_d;
  logic [W-1:0]   dout_q, dout_d, op_q, op_d;

  logic           win_vld;
  logic [SW-1:0]  win, idx;

  // First set request at or above ptr, wrapping from N-1 back to 0.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = SW'((int'(ptr_q) + k) % N);
      if (!win_vld && req_i[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    vld_d   = vld_q;
    dout_d  = dout_q;
    src_d   = src_q;
    op_d    = op_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: if (win_vld) begin
        gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
        op_d    = ~din_i[int'(win)*W +: W];
        id_d    = win;
        cnt_d   = CW'(LAT - 1);
        ptr_d   = (int'(win) == N - 1) ? '0 : win + SW'(1);
        state_d = BUSY;
      end
      BUSY: if (cnt_q == '0) begin
        dout_d  = op_q;
        src_d   = id_q;
        vld_d   = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      DONE: if (rdy_i) begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      dout_q  <= '0;
      src_q   <= '0;
      op_q    <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      dout_q  <= dout_d;
      src_q   <= src_d;
      op_q    <= op_d;
      id_q    <= id_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign vld_o  = vld_q;
  assign dout_o = dout_q;
  assign src_o  = src_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_flip_sched.sv
// Bench for flip_sched: directed scenarios plus randomized transactions against a
// transaction-level model (round-robin pick, inverted operand, fixed latency).
module tb_flip_sched;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   din;
  logic             rdy;
  logic [N-1:0]     gnt,  g1;
  logic             vld,  v1;
  logic [W-1:0]     dout, d1;
  logic [1:0]       src,  s1;
  logic             busy, b1;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  always #5 clk = ~clk;

  flip_sched #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .din_i(din), .rdy_i(rdy),
    .gnt_o(gnt), .vld_o(vld), .dout_o(dout), .src_o(src), .busy_o(busy));

  flip_sched #(.N(N), .W(W), .LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .din_i(din), .rdy_i(rdy),
    .gnt_o(g1), .vld_o(v1), .dout_o(d1), .src_o(s1), .busy_o(b1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One full transaction, starting from IDLE at #1 after an edge.
  task automatic txn(input logic [N-1:0] r, input logic [N*W-1:0] d, input int hold,
                     input bit scramble, output int w);
    logic [W-1:0] exp_d;
    logic [N-1:0] exp_g;
    w     = pick(r, mptr);
    exp_d = ~d[w*W +: W];
    exp_g = '0;
    exp_g[w] = 1'b1;
    mptr  = (w + 1) % N;
    req = r; din = d; rdy = 1'b0;
    step();
    check("grant", gnt, exp_g);
    check("busy_at_grant", busy, 1);
    check("vld_at_grant", vld, 0);
    if (scramble) begin
      din = {$urandom, $urandom};
      req = N'($urandom);
    end
    for (int i = 1; i < LAT; i++) begin
      rdy = 1'($urandom);
      step();
      check("gnt_pulse", gnt, 0);
      check("vld_early", vld, 0);
    end
    rdy = 1'($urandom);
    step();
    check("vld_rise", vld, 1);
    check("dout", dout, exp_d);
    check("src", src, w);
    check("gnt_busy", gnt, 0);
    rdy = 1'b0;
    for (int i = 0; i < hold; i++) begin
      req = N'($urandom);
      step();
      check("hold_vld", vld, 1);
      check("hold_dout", dout, exp_d);
      check("hold_src", src, w);
      check("hold_gnt", gnt, 0);
      check("hold_busy", busy, 1);
    end
    rdy = 1'b1;
    step();
    check("accept_vld", vld, 0);
    check("accept_busy", busy, 0);
    check("retain_dout", dout, exp_d);
    check("retain_src", src, w);
    check("accept_gnt", gnt, 0);
    rdy = 1'b0;
  endtask

  initial begin
    int w;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] r;
    rst = 1'b1; req = '0; din = '0; rdy = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_vld", vld, 0);
    check("rst_dout", dout, 0);
    check("rst_src", src, 0);
    check("rst_busy", busy, 0);
    step(); step();
    rst = 1'b0;

    // LAT=1 corner on the second instance
    req = 4'b0001; din = '0;
    step();
    check("lat1_gnt", g1, 4'b0001);
    req = '0;
    step();
    check("lat1_vld", v1, 1);
    check("lat1_dout", d1, 8'hFF);
    check("lat1_src", s1, 0);
    rst = 1'b1; step(); rst = 1'b0; mptr = 0;

    // Single request, requester 1
    din = '0; din[1*W +: W] = 8'h5A;
    txn(4'b0010, din, 2, 1'b0, w);
    check("single_w", w, 1);
    check("single_dout", dout, 8'hA5);

    // All requesting: order 0,1,2,3,0 after a fresh reset
    rst = 1'b1; step(); rst = 1'b0; mptr = 0;
    for (int t = 0; t < 5; t++) begin
      txn(4'b1111, {$urandom, $urandom}, 0, 1'b0, w);
      check("rr_order", w, order[t]);
    end

    // Backpressure 5 cycles with operand scrambled after grant
    txn(4'b0100, {$urandom, $urandom}, 5, 1'b1, w);
    check("bp_w", w, 2);

    // Reset one cycle after grant
    req = 4'b0001; din = {$urandom, $urandom};
    step();
    check("pre_rst_gnt", gnt, 4'b0001);
    req = '0;
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_gnt", gnt, 0);
    check("arst_vld", vld, 0);
    check("arst_dout", dout, 0);
    check("arst_src", src, 0);
    check("arst_busy", busy, 0);
    step();
    rst = 1'b0; mptr = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      check("post_rst_vld", vld, 0);
      check("post_rst_gnt", gnt, 0);
    end
    txn(4'b1000, {$urandom, $urandom}, 1, 1'b0, w);
    check("post_rst_w", w, 3);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      txn(r, {$urandom, $urandom}, $urandom_range(0, 4), 1'($urandom), w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flip_sched.md
FLIP_SCHED -- requirements
Module: flip_sched

Interface
REQ-001 Parameter N, default 4, number of requesters; legal range 2..8.
REQ-002 Parameter W, default 8, operand/result width in bits.
REQ-003 Parameter LAT, default 2, shared inversion datapath latency in cycles; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 req  input  N  per-requester level request; bit i belongs to requester i.
REQ-007 din  input  N*W  operands; requester i occupies bits [i*W +: W].
REQ-008 gnt  output  N  one-hot grant pulse, registered.
REQ-009 vld  output  1  result valid, registered.
REQ-010 dout  output  W  result, equal to bitwise inverse of the granted operand.
REQ-011 src  output  $clog2(N)  index of the requester that owns dout.
REQ-012 rdy  input  1  consumer accepts the result when vld and rdy are both 1 at a rising edge.
REQ-013 busy  output  1  1 whenever the FSM is not IDLE.

Function
REQ-014 The block SHALL share one inversion datapath among N requesters via an FSM with states IDLE, BUSY, DONE.
REQ-015 The FSM SHALL use round-robin pointer ptr, width $clog2(N), as follows.
- In IDLE with req != 0 at an edge, winner w = first set req bit at or after ptr, searching upward with wrap from N-1 to 0.
- At that edge: gnt <= onehot(w); op <= ~din[w]; id <= w; cnt <= LAT-1; ptr <= (w+1) mod N; state <= BUSY.
REQ-016 gnt SHALL be high for exactly one cycle per transaction and zero at all other times.
REQ-017 The operand SHALL be sampled only at the grant edge; din changes afterwards SHALL NOT affect dout.
REQ-018 BUSY SHALL behave as follows.
- gnt <= 0.
- If cnt == 0: dout <= op; src <= id; vld <= 1; state <= DONE.
- Otherwise cnt <= cnt-1.
- Net effect: vld rises LAT edges after the grant edge.
REQ-019 DONE SHALL hold vld, dout and src stable until an edge with rdy = 1. At that edge: vld <= 0; state <= IDLE.
REQ-020 IDLE SHALL last at least one cycle between transactions; a new grant occurs no earlier than the edge after acceptance.
REQ-021 req changes during BUSY/DONE SHALL be ignored; arbitration occurs only in IDLE.
REQ-022 A requester holding req continuously SHALL be re-arbitrated normally, with no starvation. Any requester with req held waits at most N-1 other transactions.
REQ-023 rdy while vld = 0 SHALL have no effect.
REQ-024 dout and src SHALL retain their last values after acceptance.
REQ-025 busy SHALL be combinational from state: busy = (state != IDLE).

Reset
REQ-026 rst = 1 SHALL immediately, without waiting for clk, force the following.
- state = IDLE; ptr = 0; cnt = 0.
- gnt = 0; vld = 0; dout = 0; src = 0; internal op/id = 0.
REQ-027 Reset during BUSY or DONE SHALL discard the in-flight transaction; no vld pulse follows release.
REQ-028 After rst falls, the first grant SHALL occur at the first rising edge with req != 0.

Verification
REQ-029 Single request, N=4, W=8, LAT=2: req=0010, din[1]=8'h5A at edge 0 -> gnt=0010 for cycle 1; vld=1, dout=8'hA5, src=1 from edge 2; held until rdy.
REQ-030 All requesting, rdy tied 1: req=1111 held -> grant order 0,1,2,3,0; each transaction spans LAT+2 edges; ptr wraps 3 to 0.
REQ-031 Backpressure: rdy=0 for 5 cycles after vld -> vld, dout, src stable throughout; no new gnt; busy=1. Raise rdy -> vld=0 next edge and IDLE.
REQ-032 Operand stability: change din[w] the cycle after gnt -> dout equals inverse of the value at grant edge.
REQ-033 Reset mid-BUSY: assert rst one cycle after gnt -> all outputs 0 asynchronously; after release with req=0, vld stays 0; next req=1000 grants requester 3 (ptr=0 search).
REQ-034 LAT=1 corner: req=0001, din[0]=8'h00 -> vld=1, dout=8'hFF one edge after the grant edge.
